// File: rtl/cpu_pkg.sv
// Shared ID/EX definitions: default field widths, control-bit positions and the payload layout.
// The layout keeps ctrl in the least-significant bits so a bubble clears only that slice.
package cpu_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_RADDR_W = 3;
  localparam int DEF_CTRL_W  = 4;

  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_ALUCTRL  = 2;
  localparam int CTRL_ALUSRC   = 1;
  localparam int CTRL_JUMP     = 0;

  typedef struct packed {
    logic [DEF_DATA_W-1:0]  data1;
    logic [DEF_DATA_W-1:0]  data2;
    logic [DEF_DATA_W-1:0]  extended;
    logic [DEF_RADDR_W-1:0] rd;
    logic [DEF_RADDR_W-1:0] rs1;
    logic [DEF_CTRL_W-1:0]  ctrl;
  } id_ex_payload_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// Payload register with load and clear enables. Clear zeroes only the low CLR_W
// bits (the control slice) and wins over load; data bits keep their value.
module pipe_payload_reg
  import cpu_pkg::*;
#(
  parameter int W     = $bits(id_ex_payload_t),
  parameter int CLR_W = DEF_CTRL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q[CLR_W-1:0] <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush and bubble insertion.
// Define ID_EX_SKID_EN to add a one-entry skid buffer that registers in_ready.
module id_ex_pipe_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int CTRL_W  = DEF_CTRL_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  input  logic [DATA_W-1:0]  Data1,
  input  logic [DATA_W-1:0]  Data2,
  input  logic [DATA_W-1:0]  extended,
  input  logic [RADDR_W-1:0] Rd,
  input  logic [RADDR_W-1:0] Rs1,
  input  logic [CTRL_W-1:0]  ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  Data1_q,
  output logic [DATA_W-1:0]  Data2_q,
  output logic [DATA_W-1:0]  extended_q,
  output logic [RADDR_W-1:0] Rd_q,
  output logic [RADDR_W-1:0] Rs1_q,
  output logic [CTRL_W-1:0]  ctrl_q
);

  localparam int PAY_W = 3 * DATA_W + 2 * RADDR_W + CTRL_W;

  logic [PAY_W-1:0] pay_p0;
  logic [PAY_W-1:0] out_d;
  logic [PAY_W-1:0] out_pay_p1;
  logic             out_load;
  logic             out_clear;
  logic             vld_p1;
  logic             vld_next;
  logic             accept;
  logic             deliver;

  assign pay_p0  = {Data1, Data2, extended, Rd, Rs1, ctrl};
  assign accept  = in_valid && in_ready;
  assign deliver = vld_p1 && out_ready;

`ifdef ID_EX_SKID_EN
  logic [PAY_W-1:0] skid_pay_p1;
  logic             skid_load;
  logic             skid_clear;
  logic             skid_vld_p1;
  logic             skid_vld_next;

  // Registered ready: no combinational path from out_ready back to decode.
  assign in_ready = !skid_vld_p1;

  always_comb begin
    out_load      = 1'b0;
    out_clear     = 1'b0;
    out_d         = pay_p0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    vld_next      = vld_p1;
    skid_vld_next = skid_vld_p1;
    if (flush) begin
      out_clear     = 1'b1;
      skid_clear    = 1'b1;
      vld_next      = 1'b0;
      skid_vld_next = 1'b0;
    end else if (deliver) begin
      if (skid_vld_p1) begin
        out_load      = 1'b1;
        out_d         = skid_pay_p1;
        skid_clear    = 1'b1;
        skid_vld_next = 1'b0;
      end else if (accept) begin
        out_load = 1'b1;
      end else begin
        out_clear = 1'b1;
        vld_next  = 1'b0;
      end
    end else if (accept) begin
      if (!vld_p1) begin
        out_load = 1'b1;
        vld_next = 1'b1;
      end else begin
        skid_load     = 1'b1;
        skid_vld_next = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      skid_vld_p1 <= 1'b0;
    end else begin
      skid_vld_p1 <= skid_vld_next;
    end
  end

  pipe_payload_reg #(
    .W     (PAY_W),
    .CLR_W (CTRL_W)
  ) u_skid_reg (
    .clk   (Clk),
    .rst   (Reset),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (pay_p0),
    .q     (skid_pay_p1)
  );
`else
  assign in_ready = !vld_p1 || out_ready;

  always_comb begin
    out_d     = pay_p0;
    out_load  = 1'b0;
    out_clear = 1'b0;
    vld_next  = vld_p1;
    if (flush) begin
      out_clear = 1'b1;
      vld_next  = 1'b0;
    end else if (accept) begin
      out_load = 1'b1;
      vld_next = 1'b1;
    end else if (deliver) begin
      out_clear = 1'b1;
      vld_next  = 1'b0;
    end
  end
`endif

  // Stage boundary: ID payload -> EX slot
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_next;
    end
  end

  pipe_payload_reg #(
    .W     (PAY_W),
    .CLR_W (CTRL_W)
  ) u_out_reg (
    .clk   (Clk),
    .rst   (Reset),
    .load  (out_load),
    .clear (out_clear),
    .d     (out_d),
    .q     (out_pay_p1)
  );

  assign out_valid = vld_p1;
  assign {Data1_q, Data2_q, extended_q, Rd_q, Rs1_q, ctrl_q} = out_pay_p1;

endmodule
